// File: rtl/dds_multi_gen.sv
// dds_multi_gen: N_CH-channel DDS (sine/square/triangle/saw) with phase offset, amplitude scaling and DAC strobe
module dds_multi_gen #(
  parameter int N_CH   = 2,
  parameter int CH_W   = 1,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 8,
  parameter int LUT_AW = 8
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     cfg_wr,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic [2:0]               cfg_sel,
  input  logic [ACC_W-1:0]         cfg_data,
  input  logic                     sample_tick,
  output logic [N_CH*LUT_AW-1:0]   rom_addr,
  input  logic [N_CH*OUT_W-1:0]    rom_data,
  output logic [N_CH*OUT_W-1:0]    dac_data,
  output logic                     dac_valid,
  output logic                     dac_wr_n,
  output logic                     dac_cs_n
);
  localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
  logic v1_q, v2_q, v3_q, valid_q, strb_n_q;
  always_ff @(posedge CLOCK or negedge RESET)
    if (!RESET) begin
      {v1_q, v2_q, v3_q, valid_q} <= '0;
      strb_n_q <= 1'b1;
    end else begin
      v1_q <= sample_tick;
      v2_q <= v1_q;
      v3_q <= v2_q;
      valid_q <= v3_q;
      strb_n_q <= !valid_q;
    end
  assign dac_valid = valid_q;
  assign dac_wr_n = strb_n_q;
  assign dac_cs_n = strb_n_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [ACC_W-1:0] ftw_q, poff_q, acc_q, acc_d, phase;
    logic [2:0] mode_q;
    logic [OUT_W-1:0] amp_q, duty_q, p1_q, p2_q, dac_q, rd, tri_w, wave_d;
    logic [OUT_W:0] amp_p1;
    logic [LUT_AW-1:0] addr_q;
    logic [2*OUT_W:0] prod;
    logic wr, unused_bits;
    assign wr = cfg_wr && cfg_ch == CH_W'(i);
    assign phase = acc_q + poff_q;
    assign rd = rom_data[i*OUT_W +: OUT_W];
    // Falling half of the triangle is the rising ramp inverted
    assign tri_w = {p2_q[OUT_W-2:0], 1'b0} ^ {OUT_W{p2_q[OUT_W-1]}};
    assign amp_p1 = {1'b0, amp_q} + (OUT_W+1)'(1);
    assign prod = {{(OUT_W+1){1'b0}}, wave_d} * {{OUT_W{1'b0}}, amp_p1};
    assign unused_bits = ^{phase, prod[2*OUT_W], prod[OUT_W-1:0]};
    always_comb begin
      acc_d = wr && cfg_sel == 3'd5 ? '0 : sample_tick && mode_q[2] ? acc_q + ftw_q : acc_q;
      wave_d = mode_q[1:0] == 2'd0 ? rd :
               mode_q[1:0] == 2'd1 ? {OUT_W{p2_q < duty_q}} :
               mode_q[1:0] == 2'd2 ? tri_w : p2_q;
    end
    always_ff @(posedge CLOCK or negedge RESET)
      if (!RESET) begin
        ftw_q <= '0;
        poff_q <= '0;
        mode_q <= '0;
        amp_q <= '1;
        duty_q <= MID;
        acc_q <= '0;
        p1_q <= '0;
        p2_q <= '0;
        addr_q <= '0;
        dac_q <= MID;
      end else begin
        acc_q <= acc_d;
        if (wr && cfg_sel == 3'd0) ftw_q <= cfg_data;
        if (wr && cfg_sel == 3'd1) poff_q <= cfg_data;
        if (wr && cfg_sel == 3'd2) mode_q <= cfg_data[2:0];
        if (wr && cfg_sel == 3'd3) amp_q <= cfg_data[OUT_W-1:0];
        if (wr && cfg_sel == 3'd4) duty_q <= cfg_data[OUT_W-1:0];
        if (v1_q) begin
          p1_q <= phase[ACC_W-1 -: OUT_W];
          addr_q <= phase[ACC_W-1 -: LUT_AW];
        end
        if (v2_q) p2_q <= p1_q;
        if (v3_q) dac_q <= mode_q[2] ? prod[2*OUT_W-1:OUT_W] : MID;
      end
    assign rom_addr[i*LUT_AW +: LUT_AW] = addr_q;
    assign dac_data[i*OUT_W +: OUT_W] = dac_q;
  end
endmodule

// File: tb/tb_dds_multi_gen.sv
// tb_dds_multi_gen: scoreboard bench for dds_multi_gen with a registered sine ROM model
module tb_dds_multi_gen;
  logic CLOCK = 0, RESET = 0, cfg_wr = 0, sample_tick = 0;
  logic [1:0] cfg_ch = 0;
  logic [2:0] cfg_sel = 0;
  logic [31:0] cfg_data = 0;
  logic [15:0] rom_addr, rom_data = 0, dac_data;
  logic dac_valid, dac_wr_n, dac_cs_n;
  int checks = 0, errors = 0;
  logic [15:0] exp_q[$], addr_q[$];
  logic [15:0] last_dac = 0;
  logic [4:0] tk_h;
  logic [31:0] m_ftw[2], m_poff[2], m_acc[2];
  logic [2:0] m_mode[2];
  logic [7:0] m_amp[2], m_duty[2];

  dds_multi_gen #(.N_CH(2), .CH_W(2), .ACC_W(32), .OUT_W(8), .LUT_AW(8)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .sample_tick(sample_tick), .rom_addr(rom_addr), .rom_data(rom_data),
    .dac_data(dac_data), .dac_valid(dac_valid), .dac_wr_n(dac_wr_n), .dac_cs_n(dac_cs_n)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic logic [7:0] rom_f(input logic [7:0] a);
    return a * 8'd7 + 8'd3;
  endfunction

  always @(posedge CLOCK) rom_data <= {rom_f(rom_addr[15:8]), rom_f(rom_addr[7:0])};

  always @(posedge CLOCK or negedge RESET)
    if (!RESET) tk_h <= '0;
    else tk_h <= {tk_h[3:0], sample_tick};

  function automatic logic [7:0] model_addr(input int c);
    logic [31:0] ph;
    ph = m_acc[c] + m_poff[c];
    return ph[31:24];
  endfunction

  function automatic logic [7:0] model_out(input int c);
    logic [7:0] p;
    int w;
    p = model_addr(c);
    case (m_mode[c][1:0])
      2'd0: w = int'(rom_f(p));
      2'd1: w = (p < m_duty[c]) ? 255 : 0;
      2'd2: w = (p < 8'h80) ? 2 * int'(p) : 511 - 2 * int'(p);
      default: w = int'(p);
    endcase
    w = w * (int'(m_amp[c]) + 1) / 256;
    return m_mode[c][2] ? w[7:0] : 8'h80;
  endfunction

  always @(negedge CLOCK) begin : mon
    logic [15:0] e;
    checks++;
    if (dac_valid !== tk_h[3]) begin
      errors++;
      $display("FAIL valid_timing: got %b want %b", dac_valid, tk_h[3]);
    end
    checks++;
    if (dac_wr_n !== !tk_h[4] || dac_cs_n !== !tk_h[4]) begin
      errors++;
      $display("FAIL strobe: wr_n %b cs_n %b want %b", dac_wr_n, dac_cs_n, !tk_h[4]);
    end
    if (tk_h[1]) begin
      checks++;
      if (addr_q.size() == 0) begin
        errors++;
        $display("FAIL rom_addr: no expected entry, got %h", rom_addr);
      end else begin
        e = addr_q.pop_front();
        if (rom_addr !== e) begin
          errors++;
          $display("FAIL rom_addr: got %h want %h", rom_addr, e);
        end
      end
    end
    if (tk_h[3]) begin
      checks++;
      last_dac = dac_data;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dac_data: no expected entry, got %h", dac_data);
      end else begin
        e = exp_q.pop_front();
        if (dac_data !== e) begin
          errors++;
          $display("FAIL dac_data: got %h want %h", dac_data, e);
        end
      end
    end
  end

  task automatic m_reset;
    for (int c = 0; c < 2; c++) begin
      m_ftw[c] = 0;
      m_poff[c] = 0;
      m_acc[c] = 0;
      m_mode[c] = 0;
      m_amp[c] = 8'hFF;
      m_duty[c] = 8'h80;
    end
  endtask

  // One cycle of stimulus; the model sees the tick with the registers as they were before the write.
  task automatic step(input logic tk, input logic wr, input logic [1:0] ch, input logic [2:0] sel, input logic [31:0] d);
    sample_tick = tk;
    cfg_wr = wr;
    cfg_ch = ch;
    cfg_sel = sel;
    cfg_data = d;
    if (tk) begin
      for (int c = 0; c < 2; c++)
        if (wr && ch == c && sel == 3'd5) m_acc[c] = 0;
        else if (m_mode[c][2]) m_acc[c] = m_acc[c] + m_ftw[c];
      addr_q.push_back({model_addr(1), model_addr(0)});
      exp_q.push_back({model_out(1), model_out(0)});
    end else if (wr && ch < 2 && sel == 3'd5) m_acc[ch] = 0;
    if (wr && ch < 2)
      case (sel)
        3'd0: m_ftw[ch] = d;
        3'd1: m_poff[ch] = d;
        3'd2: m_mode[ch] = d[2:0];
        3'd3: m_amp[ch] = d[7:0];
        3'd4: m_duty[ch] = d[7:0];
        default: ;
      endcase
    @(posedge CLOCK);
    @(negedge CLOCK);
    sample_tick = 0;
    cfg_wr = 0;
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [2:0] sel, input logic [31:0] d);
    step(1'b0, 1'b1, ch, sel, d);
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 2'd0, 3'd0, 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 2'd0, 3'd0, 32'd0);
  endtask

  task automatic test_reset;
    int bad;
    RESET = 0;
    m_reset();
    @(negedge CLOCK);
    repeat (3) begin
      sample_tick = 1;
      @(negedge CLOCK);
    end
    sample_tick = 0;
    checks++;
    if (dac_data !== 16'h8080) begin errors++; $display("FAIL reset_dac: got %h want 8080", dac_data); end
    checks++;
    if (rom_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", rom_addr); end
    checks++;
    if (dac_valid !== 1'b0 || dac_wr_n !== 1'b1 || dac_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_strobe: valid %b wr_n %b cs_n %b want 0 1 1", dac_valid, dac_wr_n, dac_cs_n);
    end
    RESET = 1;
    idle(2);
    cfg(2'd0, 3'd0, 32'h0100_0000);
    cfg(2'd0, 3'd2, 32'd7);
    ticks(5);
    #2 RESET = 0;
    exp_q.delete();
    addr_q.delete();
    m_reset();
    #1;
    checks++;
    if (dac_data !== 16'h8080 || rom_addr !== 16'h0000 || dac_valid !== 1'b0 || dac_wr_n !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset: dac %h addr %h valid %b wr_n %b want 8080 0000 0 1", dac_data, rom_addr, dac_valid, dac_wr_n);
    end
    @(negedge CLOCK);
    RESET = 1;
    bad = 0;
    repeat (8) begin
      @(negedge CLOCK);
      if (dac_valid || !dac_wr_n || !dac_cs_n) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL post_reset_quiet: got %0d strobes want 0", bad); end
  endtask

  task automatic test_saw;
    int lat;
    cfg(2'd0, 3'd0, 32'h0100_0000);
    cfg(2'd0, 3'd2, 32'd7);
    step(1'b1, 1'b0, 2'd0, 3'd0, 32'd0);
    lat = -1;
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      @(negedge CLOCK);
      if (dac_valid) lat = n;
    end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL saw_latency: got %0d want 3", lat); end
    ticks(259);
    idle(6);
    checks++;
    if (last_dac !== 16'h8004) begin errors++; $display("FAIL saw_wrap: got %h want 8004", last_dac); end
  endtask

  task automatic test_offset_triangle;
    cfg(2'd1, 3'd0, 32'h0100_0000);
    cfg(2'd1, 3'd1, 32'h8000_0000);
    cfg(2'd1, 3'd2, 32'd7);
    cfg(2'd0, 3'd5, 32'd0);
    cfg(2'd1, 3'd5, 32'd0);
    ticks(10);
    idle(6);
    checks++;
    if (last_dac !== 16'h8A0A) begin errors++; $display("FAIL phase_offset: got %h want 8A0A", last_dac); end
    cfg(2'd0, 3'd0, 32'h0200_0000);
    cfg(2'd0, 3'd2, 32'd6);
    cfg(2'd0, 3'd5, 32'd0);
    ticks(70);
    idle(6);
    checks++;
    if (last_dac[7:0] !== 8'hE7) begin errors++; $display("FAIL triangle_desc: got %h want E7", last_dac[7:0]); end
  endtask

  task automatic test_square_amp;
    cfg(2'd0, 3'd4, 32'h40);
    cfg(2'd0, 3'd2, 32'd5);
    cfg(2'd0, 3'd0, 32'h0100_0000);
    cfg(2'd0, 3'd5, 32'd0);
    ticks(63);
    idle(6);
    checks++;
    if (last_dac[7:0] !== 8'hFF) begin errors++; $display("FAIL square_high: got %h want FF", last_dac[7:0]); end
    ticks(1);
    idle(6);
    checks++;
    if (last_dac[7:0] !== 8'h00) begin errors++; $display("FAIL square_edge: got %h want 00", last_dac[7:0]); end
    cfg(2'd0, 3'd3, 32'h7F);
    cfg(2'd0, 3'd2, 32'd7);
    cfg(2'd0, 3'd5, 32'd0);
    ticks(255);
    idle(6);
    checks++;
    if (last_dac[7:0] !== 8'h7F) begin errors++; $display("FAIL amp_scale: got %h want 7F", last_dac[7:0]); end
  endtask

  task automatic test_sine;
    cfg(2'd0, 3'd3, 32'hFF);
    cfg(2'd0, 3'd2, 32'd4);
    cfg(2'd0, 3'd0, 32'h0080_0000);
    cfg(2'd0, 3'd5, 32'd0);
    ticks(20);
    idle(6);
    checks++;
    if (last_dac[7:0] !== 8'h49) begin errors++; $display("FAIL sine_sample: got %h want 49", last_dac[7:0]); end
    checks++;
    if (rom_addr[7:0] !== 8'h0A) begin errors++; $display("FAIL sine_addr: got %h want 0A", rom_addr[7:0]); end
  endtask

  task automatic test_corner;
    cfg(2'd0, 3'd2, 32'd7);
    cfg(2'd0, 3'd0, 32'h0100_0000);
    cfg(2'd0, 3'd5, 32'd0);
    step(1'b1, 1'b1, 2'd0, 3'd0, 32'h0200_0000);
    ticks(1);
    idle(6);
    checks++;
    if (last_dac[7:0] !== 8'h03) begin errors++; $display("FAIL ftw_coincident: got %h want 03", last_dac[7:0]); end
    step(1'b1, 1'b1, 2'd0, 3'd5, 32'd0);
    idle(6);
    checks++;
    if (last_dac[7:0] !== 8'h00) begin errors++; $display("FAIL phase_reset_tick: got %h want 00", last_dac[7:0]); end
    cfg(2'd0, 3'd2, 32'd3);
    ticks(1);
    idle(6);
    checks++;
    if (last_dac[7:0] !== 8'h80) begin errors++; $display("FAIL disabled_mid: got %h want 80", last_dac[7:0]); end
    cfg(2'd0, 3'd2, 32'd7);
    ticks(1);
    idle(6);
    checks++;
    if (last_dac[7:0] !== 8'h02) begin errors++; $display("FAIL acc_frozen: got %h want 02", last_dac[7:0]); end
    cfg(2'd3, 3'd0, 32'hFFFF_FFFF);
    cfg(2'd3, 3'd2, 32'd0);
    cfg(2'd0, 3'd6, 32'hFFFF_FFFF);
    cfg(2'd0, 3'd7, 32'hFFFF_FFFF);
    ticks(1);
    idle(6);
    checks++;
    if (last_dac[7:0] !== 8'h04) begin errors++; $display("FAIL ignored_write: got %h want 04", last_dac[7:0]); end
  endtask

  initial begin
    test_reset();
    test_saw();
    test_offset_triangle();
    test_square_amp();
    test_sine();
    test_corner();
    checks++;
    if (exp_q.size() != 0 || addr_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d data and %0d addr entries left, want 0", exp_q.size(), addr_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
